// File: rtl/aes_sbox_pkg.sv
// -----------------------------------------------------------------------------
// aes_sbox_pkg
//   Shared definitions for the shared AES S-box block. Contains the byte width,
//   the direction encodings, the stage payload struct, and the merged fwd/inv
//   S-box datapath built around a single GF(2^8) inverter (gf_inv_8).
//   Arithmetic is in the AES polynomial basis (x^8 + x^4 + x^3 + x + 1), so the
//   input/output basis change is the identity and only the affine maps remain.
// -----------------------------------------------------------------------------
package aes_sbox_pkg;

    localparam int   BYTE_W   = 8;
    localparam logic SBOX_FWD = 1'b0;
    localparam logic SBOX_INV = 1'b1;

    // Byte payload carried through both pipeline stages (id travels alongside,
    // since its width depends on the instance's N_REQ).
    typedef struct packed {
        logic              dec;
        logic [BYTE_W-1:0] data;
    } sbox_op_t;

    function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                                 input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] p;
        logic [BYTE_W-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < BYTE_W; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (addition chain); maps 0 to 0 as AES needs.
    function automatic logic [BYTE_W-1:0] gf_inv_8(input logic [BYTE_W-1:0] x);
        logic [BYTE_W-1:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [BYTE_W-1:0] affine_fwd(input logic [BYTE_W-1:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
                 ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [BYTE_W-1:0] affine_inv(input logic [BYTE_W-1:0] a);
        return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    endfunction

    // Merged datapath: the inverter is shared, the affine step moves to the
    // input side for the inverse direction and to the output side for forward.
    function automatic logic [BYTE_W-1:0] sbox_merged(input logic [BYTE_W-1:0] x,
                                                      input logic              dec);
        logic [BYTE_W-1:0] inv;
        inv = gf_inv_8((dec == SBOX_INV) ? affine_inv(x) : x);
        return (dec == SBOX_INV) ? inv : affine_fwd(inv);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational one-hot arbiter. Round-robin from ptr upward (wrapping) when
//   RR_EN=1, fixed lowest-index priority when RR_EN=0.
//   Ports:
//     req     in  N_REQ  request vector
//     en      in  1      grant permitted this cycle
//     ptr     in  ID_W   current round-robin start index
//     gnt     out N_REQ  one-hot grant (all zero when en=0 or no request)
//     ptr_nxt out ID_W   pointer to load when the grant is taken
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N_REQ = 4,
    parameter  bit RR_EN = 1'b1,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  ptr_nxt
);

    int   start;
    int   win;
    logic found;

    // Two ascending passes: indices at/above start first, then the wrapped ones
    // below start. This avoids a modulo index into req.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no
        // path leaves it unassigned, which would infer a latch.
        gnt     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        win     = 0;
        start   = RR_EN ? int'(ptr) : 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (en && !found && req[i] && i >= start) begin
                found  = 1'b1;
                win    = i;
                gnt[i] = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (en && !found && req[i] && i < start) begin
                found  = 1'b1;
                win    = i;
                gnt[i] = 1'b1;
            end
        end
        if (found) ptr_nxt = RR_EN ? ID_W'((win + 1) % N_REQ) : '0;
    end

endmodule

// File: rtl/sbox_share_arbiter.sv
// -----------------------------------------------------------------------------
// sbox_share_arbiter
//   Shares one merged fwd/inv AES S-box between N_REQ byte requesters through a
//   two-stage valid/ready pipeline: S1 holds the granted byte, S2 holds the
//   S-box result and drives the response port.
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     req_valid  in  N_REQ    per-requester valid
//     req_dec    in  N_REQ    per-requester direction (1 = inverse S-box)
//     req_data   in  8*N_REQ  byte i at [8i+7:8i]
//     req_ready  out N_REQ    one-hot grant (combinational from req_valid)
//     rsp_valid  out 1        result valid
//     rsp_ready  in  1        downstream accepts the result
//     rsp_data   out 8        S-box / inverse S-box result
//     rsp_id     out ID_W     originating requester
//     rsp_dec    out 1        direction of the result
//     busy       out 1        any stage occupied
// -----------------------------------------------------------------------------
module sbox_share_arbiter
    import aes_sbox_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  bit RR_EN = 1'b1,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_dec,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [BYTE_W-1:0]       rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_dec,
    output logic                    busy
);

    logic              s1_v, s2_v;
    sbox_op_t          s1_op, s2_op;
    logic [ID_W-1:0]   s1_id, s2_id;
    logic [ID_W-1:0]   rr_ptr, ptr_nxt;
    logic              adv1, adv2, grant;
    logic [N_REQ-1:0]  gnt;
    sbox_op_t          sel_op;
    logic [ID_W-1:0]   sel_id;
    logic [BYTE_W-1:0] sbox_out;

    // A stage may load when it is empty or its content moves on this cycle.
    assign adv2 = !s2_v || rsp_ready;
    assign adv1 = !s1_v || adv2;

    rr_arbiter #(.N_REQ(N_REQ), .RR_EN(RR_EN)) u_arb (
        .req     (req_valid),
        .en      (adv1 && !rst),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .ptr_nxt (ptr_nxt)
    );

    assign req_ready = gnt;
    assign grant     = |gnt;

    always_comb begin
        sel_op = '0;
        sel_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_op.data = req_data[BYTE_W*i +: BYTE_W];
                sel_op.dec  = req_dec[i];
                sel_id      = ID_W'(i);
            end
        end
    end

    assign sbox_out = sbox_merged(s1_op.data, s1_op.dec);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            s1_v   <= 1'b0;
            s2_v   <= 1'b0;
            s1_op  <= '0;
            s2_op  <= '0;
            s1_id  <= '0;
            s2_id  <= '0;
            rr_ptr <= '0;
        end else begin
            // S2 only reloads from a valid S1, so a held result never changes.
            if (adv2) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_op <= '{dec: s1_op.dec, data: sbox_out};
                    s2_id <= s1_id;
                end
            end
            if (adv1) begin
                s1_v <= grant;
                if (grant) begin
                    s1_op <= sel_op;
                    s1_id <= sel_id;
                end
            end
            if (grant) rr_ptr <= ptr_nxt;
        end
    end

    assign rsp_valid = s2_v;
    assign rsp_data  = s2_op.data;
    assign rsp_id    = s2_id;
    assign rsp_dec   = s2_op.dec;
    assign busy      = s1_v || s2_v;

endmodule

// File: tb/tb_sbox_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sbox_share_arbiter
//   Directed bench for sbox_share_arbiter. Two instances share all inputs:
//   dut (round-robin) and dut_fp (fixed priority). Inputs change 1 time unit
//   after the rising edge; outputs are compared at that point too.
// -----------------------------------------------------------------------------
module tb_sbox_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_dec;
    logic [31:0] req_data;
    logic        rsp_ready;

    logic [3:0]  req_ready, fp_req_ready;
    logic        rsp_valid, fp_rsp_valid;
    logic [7:0]  rsp_data, fp_rsp_data;
    logic [1:0]  rsp_id, fp_rsp_id;
    logic        rsp_dec, fp_rsp_dec;
    logic        busy, fp_busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sbox_share_arbiter #(.N_REQ(4), .RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_dec(req_dec),
        .req_data(req_data), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_dec(rsp_dec), .busy(busy)
    );

    sbox_share_arbiter #(.N_REQ(4), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_dec(req_dec),
        .req_data(req_data), .req_ready(fp_req_ready), .rsp_valid(fp_rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(fp_rsp_data), .rsp_id(fp_rsp_id),
        .rsp_dec(fp_rsp_dec), .busy(fp_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic [7:0] d, input logic [1:0] id,
                           input logic dec);
        chk({tag, "_valid"}, rsp_valid, 1'b1);
        chk({tag, "_data"}, rsp_data, d);
        chk({tag, "_id"}, rsp_id, id);
        chk({tag, "_dec"}, rsp_dec, dec);
    endtask

    logic [7:0] t3_exp [4] = '{8'h7C, 8'hED, 8'hCA, 8'h16};
    logic       seen3;
    int         grants_to3;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_dec   = '0;
        req_data  = '0;
        rsp_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_rsp_id", rsp_id, 2'd0);
        chk("rst_rsp_dec", rsp_dec, 1'b0);
        chk("rst_busy", busy, 1'b0);
        req_valid = 4'hF;
        #1;
        chk("rst_req_ready", req_ready, 4'b0000);
        req_valid = '0;
        rst       = 1'b0;

        // 1: single forward request of 0x00
        req_valid = 4'b0001;
        #1;
        chk("t1_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        chk("t1_lat1_valid", rsp_valid, 1'b0);
        chk("t1_lat1_busy", busy, 1'b1);
        tick();
        chk_rsp("t1_rsp", 8'h63, 2'd0, 1'b0);
        chk("t1_lat2_busy", busy, 1'b1);
        tick();
        chk("t1_drain_valid", rsp_valid, 1'b0);
        chk("t1_drain_busy", busy, 1'b0);

        // 2: requester 1 inverse 0x63 then 0xED, back to back
        req_valid = 4'b0010;
        req_dec   = 4'b0010;
        req_data[15:8] = 8'h63;
        #1;
        chk("t2_grant", req_ready, 4'b0010);
        tick();
        req_data[15:8] = 8'hED;
        chk("t2_lat1_valid", rsp_valid, 1'b0);
        chk("t2_grant2", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        chk_rsp("t2_rsp0", 8'h00, 2'd1, 1'b1);
        tick();
        chk_rsp("t2_rsp1", 8'h53, 2'd1, 1'b1);
        tick();
        chk("t2_drain_valid", rsp_valid, 1'b0);

        // Reset between tests brings the round-robin pointer back to 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_busy", busy, 1'b0);

        // 3: all four requesters continuously, forward direction
        req_valid = 4'hF;
        req_dec   = 4'h0;
        req_data  = 32'hFF10_5301;
        #1;
        chk("t3_grant0", req_ready, 4'b0001);
        for (int n = 1; n <= 8; n++) begin
            tick();
            chk($sformatf("t3_grant_c%0d", n), req_ready, 4'b0001 << (n % 4));
            if (n >= 2) chk_rsp($sformatf("t3_rsp_c%0d", n), t3_exp[(n - 2) % 4],
                                2'((n - 2) % 4), 1'b0);
        end
        req_valid = '0;
        tick();
        chk_rsp("t3_rsp_last", 8'h16, 2'd3, 1'b0);
        tick();
        chk("t3_drain_valid", rsp_valid, 1'b0);

        // 4: fill the pipe, stall the output for 5 clocks, then release
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("t4_grant0", req_ready, 4'b0001);
        tick();
        chk("t4_fill_valid", rsp_valid, 1'b0);
        chk("t4_grant1", req_ready, 4'b0010);
        tick();
        chk_rsp("t4_full", 8'h7C, 2'd0, 1'b0);
        chk("t4_full_ready", req_ready, 4'b0000);
        for (int n = 0; n < 5; n++) begin
            tick();
            chk($sformatf("t4_stall_ready_%0d", n), req_ready, 4'b0000);
            chk_rsp($sformatf("t4_stall_%0d", n), 8'h7C, 2'd0, 1'b0);
            chk($sformatf("t4_stall_busy_%0d", n), busy, 1'b1);
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        tick();
        chk_rsp("t4_rel", 8'hED, 2'd1, 1'b0);
        tick();
        chk("t4_drain_valid", rsp_valid, 1'b0);
        chk("t4_drain_busy", busy, 1'b0);

        // 5: reset with both stages occupied (pointer is at 2 here)
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        tick();
        tick();
        chk_rsp("t5_full", 8'hCA, 2'd2, 1'b0);
        chk("t5_full_busy", busy, 1'b1);
        rst       = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("t5_rst_ready", req_ready, 4'b0000);
        tick();
        rst       = 1'b0;
        req_valid = '0;
        chk("t5_valid", rsp_valid, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_data", rsp_data, 8'h00);
        chk("t5_id", rsp_id, 2'd0);
        req_valid = 4'hF;
        #1;
        chk("t5_ptr0", req_ready, 4'b0001);
        req_valid = '0;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk($sformatf("t5_stale_%0d", n), rsp_valid, 1'b0);
        end

        // 6: requesters 0 and 3 always valid, round-robin vs fixed priority
        req_valid  = 4'b1001;
        req_dec    = 4'h0;
        req_data   = 32'hFF00_0000;
        seen3      = 1'b0;
        grants_to3 = 0;
        #1;
        for (int n = 0; n < 6; n++) begin
            chk($sformatf("t6_fp_grant_%0d", n), fp_req_ready, 4'b0001);
            chk($sformatf("t6_rr_grant_%0d", n), req_ready,
                (n % 2 == 0) ? 4'b0001 : 4'b1000);
            if (!seen3) grants_to3++;
            if (req_ready[3]) seen3 = 1'b1;
            tick();
            if (n >= 1) begin
                chk_rsp($sformatf("t6_rr_rsp_%0d", n),
                        ((n - 1) % 2 == 0) ? 8'h63 : 8'h16,
                        ((n - 1) % 2 == 0) ? 2'd0 : 2'd3, 1'b0);
                chk($sformatf("t6_fp_valid_%0d", n), fp_rsp_valid, 1'b1);
                chk($sformatf("t6_fp_id_%0d", n), fp_rsp_id, 2'd0);
                chk($sformatf("t6_fp_data_%0d", n), fp_rsp_data, 8'h63);
            end
        end
        chk("t6_fair", (seen3 && grants_to3 <= 4) ? 1'b1 : 1'b0, 1'b1);
        req_valid = '0;
        tick();
        tick();
        chk("t6_drain_busy", busy, 1'b0);
        chk("t6_fp_drain_busy", fp_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
